// File: rtl/runahead_pkg.sv
// Shared types and constants for the runahead scheduler and its replay buffer.
package runahead_pkg;

  localparam int unsigned DefaultDepth = 16;

  typedef logic [15:0] instr_t;
  typedef logic [15:0] pc_t;

  typedef enum logic [1:0] {
    StIdle,
    StRunahead,
    StReplay,
    StRedirect
  } state_e;

endpackage

// File: rtl/runahead_replay_buffer.sv
// Circular FIFO holding instructions fetched during runahead for later replay.
module runahead_replay_buffer
  import runahead_pkg::*;
#(
  parameter int unsigned Depth = DefaultDepth,
  parameter int unsigned PtrW  = $clog2(Depth)
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          push,
  input  instr_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output instr_t        head,
  output logic [PtrW:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned CountW = PtrW + 1;

  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CountW-1:0] count_q;
  instr_t            mem_q [Depth];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (sync_rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (do_push) begin
      wr_ptr_q <= wr_ptr_q + PtrW'(1);
      count_q  <= count_q + CountW'(1);
    end else if (do_pop) begin
      rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q  <= count_q - CountW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CountW'(Depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/runahead_scheduler.sv
// Runahead episode FSM: buffers fetched instructions during a miss, then replays
// them into the selector or redirects fetch to the checkpoint PC on overflow.
module runahead_scheduler
  import runahead_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           sync_rst,
  input  logic           RunaheadTrigger,
  input  logic [15:0]    TriggerPC,
  input  logic           MissResolved,
  input  logic           FetchedInstructionValid,
  input  logic [15:0]    FetchedInstruction,
  input  logic           DownstreamReady,
  output logic           ReplayValid,
  output logic [15:0]    ReplayInstruction,
  output logic           InRunahead,
  output logic           RedirectValid,
  output logic [15:0]    RedirectPC,
  output logic [PTR_W:0] BufferCount
);

  state_e state_q, state_d;
  pc_t    checkpoint_q, checkpoint_d;
  logic   overflow_q, overflow_d;

  logic         buf_push;
  logic         buf_pop;
  logic         buf_flush;
  instr_t       buf_head;
  logic [PTR_W:0] buf_count;
  logic         buf_full;
  logic         buf_empty;

  runahead_replay_buffer #(
    .Depth (DEPTH),
    .PtrW  (PTR_W)
  ) u_replay_buffer (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .push      (buf_push),
    .push_data (FetchedInstruction),
    .pop       (buf_pop),
    .flush     (buf_flush),
    .head      (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q      <= StIdle;
      checkpoint_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      checkpoint_q <= checkpoint_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    checkpoint_d = checkpoint_q;
    overflow_d   = overflow_q;
    buf_push     = 1'b0;
    buf_pop      = 1'b0;
    buf_flush    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (RunaheadTrigger) begin
          state_d      = StRunahead;
          checkpoint_d = TriggerPC;
          overflow_d   = 1'b0;
          // Normally already empty here; leaving pointers alone lets them rotate.
          buf_flush    = !buf_empty;
        end
      end
      StRunahead: begin
        if (FetchedInstructionValid) begin
          if (buf_full) begin
            overflow_d = 1'b1;
          end else begin
            buf_push = 1'b1;
          end
        end
        if (MissResolved) begin
          if (overflow_d) begin
            state_d = StRedirect;
          end else if (!buf_empty || buf_push) begin
            state_d = StReplay;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StReplay: begin
        buf_pop = DownstreamReady;
        if (DownstreamReady && buf_count == (PTR_W+1)'(1)) begin
          state_d = StIdle;
        end
      end
      StRedirect: begin
        buf_flush = 1'b1;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ReplayValid       = (state_q == StReplay);
  assign ReplayInstruction = ReplayValid ? buf_head : '0;
  assign InRunahead        = (state_q == StRunahead);
  assign RedirectValid     = (state_q == StRedirect);
  assign RedirectPC        = RedirectValid ? checkpoint_q : '0;
  assign BufferCount       = buf_count;

endmodule

// File: tb/tb_runahead_scheduler.sv
// Scoreboard bench for runahead_scheduler: stimulus queues expected replay and
// redirect events, a negedge monitor pops and compares them.
module tb_runahead_scheduler;

  localparam int unsigned Depth = 16;

  logic        clk;
  logic        sync_rst;
  logic        RunaheadTrigger;
  logic [15:0] TriggerPC;
  logic        MissResolved;
  logic        FetchedInstructionValid;
  logic [15:0] FetchedInstruction;
  logic        DownstreamReady;
  logic        ReplayValid;
  logic [15:0] ReplayInstruction;
  logic        InRunahead;
  logic        RedirectValid;
  logic [15:0] RedirectPC;
  logic [4:0]  BufferCount;

  runahead_scheduler #(
    .DEPTH (Depth),
    .PTR_W (4)
  ) dut (
    .clk                     (clk),
    .sync_rst                (sync_rst),
    .RunaheadTrigger         (RunaheadTrigger),
    .TriggerPC               (TriggerPC),
    .MissResolved            (MissResolved),
    .FetchedInstructionValid (FetchedInstructionValid),
    .FetchedInstruction      (FetchedInstruction),
    .DownstreamReady         (DownstreamReady),
    .ReplayValid             (ReplayValid),
    .ReplayInstruction       (ReplayInstruction),
    .InRunahead              (InRunahead),
    .RedirectValid           (RedirectValid),
    .RedirectPC              (RedirectPC),
    .BufferCount             (BufferCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_redir;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q [$];
  logic [15:0] m_buf [$];
  logic        m_ovf;
  logic [15:0] m_pc;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every replay/redirect the DUT presents must match the queue head.
  always @(negedge clk) begin
    if (!sync_rst) begin
      if (ReplayValid) begin
        chk("replay_expected", {31'b0, exp_q.size() != 0 && !exp_q[0].is_redir}, 32'd1);
        if (exp_q.size() != 0 && !exp_q[0].is_redir) begin
          chk("replay_data", {16'b0, ReplayInstruction}, {16'b0, exp_q[0].val});
          if (DownstreamReady) void'(exp_q.pop_front());
        end
      end else begin
        chk("replay_idle_zero", {16'b0, ReplayInstruction}, 32'd0);
      end
      if (RedirectValid) begin
        chk("redirect_expected", {31'b0, exp_q.size() != 0 && exp_q[0].is_redir}, 32'd1);
        if (exp_q.size() != 0 && exp_q[0].is_redir) begin
          chk("redirect_pc", {16'b0, RedirectPC}, {16'b0, exp_q[0].val});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve_model();
    if (m_ovf) begin
      exp_q.push_back('{is_redir: 1'b1, val: m_pc});
    end else begin
      foreach (m_buf[i]) exp_q.push_back('{is_redir: 1'b0, val: m_buf[i]});
    end
    m_buf.delete();
  endtask

  task automatic do_trigger(input logic [15:0] pc);
    RunaheadTrigger = 1'b1;
    TriggerPC       = pc;
    m_pc            = pc;
    m_ovf           = 1'b0;
    m_buf.delete();
    step();
    RunaheadTrigger = 1'b0;
    TriggerPC       = '0;
  endtask

  task automatic do_fetch(input logic [15:0] ins, input logic miss);
    FetchedInstructionValid = 1'b1;
    FetchedInstruction      = ins;
    MissResolved            = miss;
    if (m_buf.size() < Depth) m_buf.push_back(ins);
    else m_ovf = 1'b1;
    if (miss) resolve_model();
    step();
    FetchedInstructionValid = 1'b0;
    FetchedInstruction      = '0;
    MissResolved            = 1'b0;
  endtask

  task automatic do_miss();
    MissResolved = 1'b1;
    resolve_model();
    step();
    MissResolved = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!InRunahead && !ReplayValid && !RedirectValid) done = 1'b1;
    end
    chk(name, {31'b0, done}, 32'd1);
    chk({name, "_count"}, {27'b0, BufferCount}, 32'd0);
    chk({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    sync_rst                = 1'b1;
    RunaheadTrigger         = 1'b0;
    TriggerPC               = '0;
    MissResolved            = 1'b0;
    FetchedInstructionValid = 1'b0;
    FetchedInstruction      = '0;
    DownstreamReady         = 1'b1;
    m_ovf                   = 1'b0;
    m_pc                    = '0;
    step();
    step();
    sync_rst = 1'b0;
    @(negedge clk);
    chk("reset_inrunahead", {31'b0, InRunahead}, 32'd0);
    chk("reset_count", {27'b0, BufferCount}, 32'd0);
    chk("reset_redirect_pc", {16'b0, RedirectPC}, 32'd0);

    // Basic replay of three instructions.
    do_trigger(16'h0040);
    @(negedge clk);
    chk("trigger_inrunahead", {31'b0, InRunahead}, 32'd1);
    do_fetch(16'h1111, 1'b0);
    do_fetch(16'h2222, 1'b0);
    do_fetch(16'h3333, 1'b0);
    @(negedge clk);
    chk("basic_count3", {27'b0, BufferCount}, 32'd3);
    do_miss();
    wait_idle("basic_idle");

    // Backpressure: stall two cycles while 0x2222 is the head.
    do_trigger(16'h0040);
    do_fetch(16'h1111, 1'b0);
    do_fetch(16'h2222, 1'b0);
    do_fetch(16'h3333, 1'b0);
    do_miss();
    step();
    DownstreamReady = 1'b0;
    step();
    step();
    DownstreamReady = 1'b1;
    wait_idle("backpressure_idle");

    // Overflow: 17 fetches, separate resolve.
    do_trigger(16'h0040);
    for (int i = 0; i < 17; i++) do_fetch(16'hA000 + 16'(i), 1'b0);
    @(negedge clk);
    chk("overflow_count16", {27'b0, BufferCount}, 32'd16);
    do_miss();
    wait_idle("overflow_idle");

    // Resolve coincident with the 16th fetch: full replay of 16.
    do_trigger(16'h0100);
    for (int i = 0; i < 16; i++) do_fetch(16'hB000 + 16'(i), i == 15);
    wait_idle("full16_idle");

    // Resolve coincident with a 17th fetch: redirect.
    do_trigger(16'h0200);
    for (int i = 0; i < 17; i++) do_fetch(16'hC000 + 16'(i), i == 16);
    wait_idle("miss17_idle");

    // Resolve with nothing captured.
    do_trigger(16'h0300);
    do_miss();
    @(negedge clk);
    chk("empty_inrunahead", {31'b0, InRunahead}, 32'd0);
    wait_idle("empty_idle");

    // MissResolved in IDLE is ignored.
    MissResolved = 1'b1;
    step();
    MissResolved = 1'b0;
    @(negedge clk);
    chk("idle_miss_inrunahead", {31'b0, InRunahead}, 32'd0);
    chk("idle_miss_replay", {31'b0, ReplayValid}, 32'd0);

    // Trigger during REPLAY is ignored.
    do_trigger(16'h0400);
    do_fetch(16'h4444, 1'b0);
    do_fetch(16'h5555, 1'b0);
    DownstreamReady = 1'b0;
    do_miss();
    RunaheadTrigger = 1'b1;
    TriggerPC       = 16'hBEEF;
    step();
    RunaheadTrigger = 1'b0;
    TriggerPC       = '0;
    @(negedge clk);
    chk("replay_trig_inrunahead", {31'b0, InRunahead}, 32'd0);
    chk("replay_trig_valid", {31'b0, ReplayValid}, 32'd1);
    DownstreamReady = 1'b1;
    wait_idle("replay_trig_idle");

    // Reset mid-REPLAY.
    do_trigger(16'h0500);
    do_fetch(16'h6666, 1'b0);
    do_fetch(16'h7777, 1'b0);
    DownstreamReady = 1'b0;
    do_miss();
    @(negedge clk);
    chk("pre_reset_replay", {31'b0, ReplayValid}, 32'd1);
    sync_rst = 1'b1;
    step();
    sync_rst = 1'b0;
    exp_q.delete();
    DownstreamReady = 1'b1;
    @(negedge clk);
    chk("rst_replay_valid", {31'b0, ReplayValid}, 32'd0);
    chk("rst_replay_instr", {16'b0, ReplayInstruction}, 32'd0);
    chk("rst_inrunahead", {31'b0, InRunahead}, 32'd0);
    chk("rst_redirect", {31'b0, RedirectValid}, 32'd0);
    chk("rst_count", {27'b0, BufferCount}, 32'd0);

    // Three back-to-back episodes of seven: pointers wrap across episodes.
    for (int e = 0; e < 3; e++) begin
      do_trigger(16'h0600 + 16'(e));
      for (int i = 0; i < 7; i++) do_fetch(16'hD000 + 16'(e * 16 + i), i == 6);
      wait_idle("wrap_idle");
    end

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
